uart_rx_dma_writer: RTL

- Downstream of the user-project UART receiver. Consumes received bytes over a valid/ready stream.
- Packs the bytes little-endian into 32-bit words and writes them to user memory as a Wishbone master.
- Firmware programs base address and byte count, pulses start, then polls done/err.
- Completion is reported on the la/checkbits path as the 0xAB5x signature.

---
 rtl/uart_dma_pkg.sv | 25 ++
 rtl/uart_dma_fifo.sv | 60 ++++++
 rtl/uart_rx_dma_writer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_dma_pkg.sv
// Shared types and helpers for the UART DMA paths.
// The writer FSM states and the byte-count to byte-enable mapping live here.
package uart_dma_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } dma_state_e;

    localparam logic [3:0] SEL_FULL = 4'hF;

    // Byte enables for a word holding 'count' low-order bytes (1..4).
    function automatic logic [3:0] sel_for_count(input logic [2:0] count);
        case (count)
            3'd1:    sel_for_count = 4'b0001;
            3'd2:    sel_for_count = 4'b0011;
            3'd3:    sel_for_count = 4'b0111;
            default: sel_for_count = SEL_FULL;
        endcase
    endfunction

endpackage

// File: rtl/uart_dma_fifo.sv
// Synchronous FIFO with show-ahead head word, full/empty flags and flush.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module uart_dma_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full     = (r_count == (AW+1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign w_do_pop   = i_pop && !o_empty;
    assign w_do_push  = i_push && (!o_full || w_do_pop);
    assign o_pop_data = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_srst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_dma_writer.sv
// Packs UART receive bytes little-endian into 32-bit words and writes them
// to memory as a single-beat Wishbone master, with error/timeout abort.
module uart_rx_dma_writer
    import uart_dma_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 255,
    parameter int LEN_W       = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    input  logic [31:0]      cfg_base_addr,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] words_written,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic             wbm_err_i
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    dma_state_e       r_state;
    logic [LEN_W-1:0] r_bytes_left;
    logic [1:0]       r_byte_lane;
    logic [31:0]      r_cur_addr;
    logic [TMO_W-1:0] r_tmo;
    logic             r_cyc;
    logic             r_stb;
    logic             r_we;
    logic [3:0]       r_sel;
    logic [31:0]      r_dat;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [LEN_W-1:0] r_words;

    logic             w_accept;
    logic             w_last;
    logic             w_push;
    logic [31:0]      w_push_word;
    logic [3:0]       w_push_sel;
    logic [35:0]      w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_abort;
    logic             w_tmo_hit;
    logic             w_wr_en;
    logic             w_flush;

    assign w_tmo_hit = r_stb && (r_tmo == TMO_W'(ACK_TIMEOUT));
    assign w_abort   = r_cyc && (wbm_err_i || w_tmo_hit);
    assign w_pop     = r_cyc && wbm_ack_i && !w_abort;
    assign w_wr_en   = (r_state == RUN) || (r_state == DRAIN);
    assign w_flush   = (r_state == ERR);

    // No byte is taken on the cycle a bus abort is detected.
    assign rx_ready   = (r_state == RUN) && (r_bytes_left != '0) && !w_full && !w_abort;
    assign w_accept   = rx_valid && rx_ready;
    assign w_last     = (r_bytes_left == LEN_W'(1));
    assign w_push     = w_accept && ((r_byte_lane == 2'd3) || w_last);
    assign w_push_sel = sel_for_count({1'b0, r_byte_lane} + 3'd1);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            if (gi < 3) begin : g_stored
                logic [7:0] r_lane;
                always_ff @(posedge wb_clk_i) begin
                    if (wb_rst_i) begin
                        r_lane <= '0;
                    end else if (w_accept && (r_byte_lane == 2'(gi))) begin
                        r_lane <= rx_data;
                    end
                end
                assign w_push_word[8*gi +: 8] = (r_byte_lane == 2'(gi)) ? rx_data :
                                                (r_byte_lane >  2'(gi)) ? r_lane  : 8'h00;
            end else begin : g_top
                assign w_push_word[8*gi +: 8] = (r_byte_lane == 2'(gi)) ? rx_data : 8'h00;
            end
        end
    endgenerate

    uart_dma_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (36)
    ) u_fifo (
        .i_clk       (wb_clk_i),
        .i_srst      (wb_rst_i),
        .i_flush     (w_flush),
        .i_push      (w_push),
        .i_push_data ({w_push_sel, w_push_word}),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state      <= IDLE;
            r_bytes_left <= '0;
            r_byte_lane  <= '0;
            r_cur_addr   <= '0;
            r_tmo        <= '0;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_we         <= 1'b0;
            r_sel        <= '0;
            r_dat        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_words      <= '0;
        end else begin
            // Writer: one single-beat cycle at a time, idle for a cycle between.
            if (r_cyc) begin
                if (w_abort) begin
                    r_cyc <= 1'b0;
                    r_stb <= 1'b0;
                    r_we  <= 1'b0;
                    r_tmo <= '0;
                end else if (wbm_ack_i) begin
                    r_cyc      <= 1'b0;
                    r_stb      <= 1'b0;
                    r_we       <= 1'b0;
                    r_tmo      <= '0;
                    r_cur_addr <= r_cur_addr + 32'd4;
                    r_words    <= r_words + 1'b1;
                end else begin
                    r_tmo <= r_tmo + 1'b1;
                end
            end else if (w_wr_en && !w_empty) begin
                r_cyc <= 1'b1;
                r_stb <= 1'b1;
                r_we  <= 1'b1;
                r_sel <= w_head[35:32];
                r_dat <= w_head[31:0];
                r_tmo <= TMO_W'(1);
            end

            case (r_state)
                IDLE: begin
                    if (cfg_start) begin
                        r_cur_addr   <= cfg_base_addr & 32'hFFFF_FFFC;
                        r_bytes_left <= cfg_len;
                        r_byte_lane  <= '0;
                        r_err        <= 1'b0;
                        r_words      <= '0;
                        if (cfg_len == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_done  <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_abort) begin
                        r_state <= ERR;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (w_accept) begin
                        r_byte_lane  <= r_byte_lane + 2'd1;
                        r_bytes_left <= r_bytes_left - 1'b1;
                        if (w_last) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_abort) begin
                        r_state <= ERR;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (w_empty && !r_cyc) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                DONE:    r_state <= IDLE;
                ERR:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign words_written = r_words;
    assign wbm_cyc_o     = r_cyc;
    assign wbm_stb_o     = r_stb;
    assign wbm_we_o      = r_we;
    assign wbm_sel_o     = r_sel;
    assign wbm_adr_o     = r_cur_addr;
    assign wbm_dat_o     = r_dat;

endmodule
